// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end.
//   PC_STEP        : byte distance between sequential instructions
//   PC_PIPE_OFFSET : the branch base is the branch address plus two instructions
//   fetch_state_e  : fetch sequencer state encoding
//   next_seq_pc    : sequential PC increment, wraps at 2^32
package cpu_pkg;

    localparam logic [31:0] PC_STEP        = 32'd4;
    localparam logic [31:0] PC_PIPE_OFFSET = 32'd8;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_SQUASH = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Branch target computation, purely combinational.
//   branch_pc    in  32 : address of the branch instruction
//   immediate_32 in  32 : sign-extended word offset
//   target       out 32 : branch_pc + 8 + offset*4, wrapping at 2^32
module branch_target_adder
    import cpu_pkg::*;
(
    input  logic [31:0] branch_pc,
    input  logic [31:0] immediate_32,
    output logic [31:0] target
);

    // The 32-bit shift drops immediate_32[31:30]; overflow wraps silently.
    assign target = branch_pc + PC_PIPE_OFFSET + (immediate_32 << 2);

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch PC sequencer with branch redirect and downstream stall.
//   clk, reset         : single clock, synchronous active-high reset
//   stall              : downstream not ready; holds fetch and the output
//   branch_taken       : redirect request (branch_pc, immediate_32)
//   imem_addr/imem_req : instruction memory request, accepted with imem_ready
//   imem_rdata         : read data, valid the cycle after acceptance
//   instr/instr_pc     : fetched instruction and its address, qualified by instr_valid
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_BOOT   | first cycle after reset, no request issued
// ST_FETCH  | issue requests at pc, deliver returned data
// ST_SQUASH | one dead cycle after a redirect, no request, output invalid
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc,
    input  logic [31:0] immediate_32,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  instr_pc_q;
    logic         instr_valid_q;

    // Request accepted last cycle; its data is on imem_rdata now.
    logic         pend_q;
    logic [31:0]  pend_pc_q;

    // Data that returned while stalled, parked until the stall releases.
    logic         skid_valid_q;
    logic [31:0]  skid_instr_q;
    logic [31:0]  skid_pc_q;

    logic [31:0]  branch_target;
    logic         accept;

    branch_target_adder u_target (
        .branch_pc    (branch_pc),
        .immediate_32 (immediate_32),
        .target       (branch_target)
    );

    // A pending redirect still requests, but anything accepted that cycle is dropped.
    assign imem_req    = !reset && (state_q == ST_FETCH) && (!stall || branch_taken);
    assign accept      = imem_req && imem_ready;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            pend_q        <= 1'b0;
            pend_pc_q     <= '0;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
        end else if (branch_taken && (state_q != ST_BOOT)) begin
            pc_q          <= branch_target;
            state_q       <= ST_SQUASH;
            pend_q        <= 1'b0;
            skid_valid_q  <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q      <= ST_FETCH;
                    pend_q       <= 1'b0;
                    skid_valid_q <= 1'b0;
                end
                ST_SQUASH: begin
                    state_q       <= ST_FETCH;
                    instr_valid_q <= 1'b0;
                end
                ST_FETCH: begin
                    if (stall) begin
                        // No request goes out while stalled, so only returning data moves.
                        if (pend_q) begin
                            skid_valid_q <= 1'b1;
                            skid_instr_q <= imem_rdata;
                            skid_pc_q    <= pend_pc_q;
                        end
                        pend_q <= 1'b0;
                    end else begin
                        pend_q <= accept;
                        if (accept) begin
                            pc_q      <= next_seq_pc(pc_q);
                            pend_pc_q <= pc_q;
                        end
                        // Pend and skid are never both set: the skid fills only while stalled.
                        if (pend_q) begin
                            instr_q       <= imem_rdata;
                            instr_pc_q    <= pend_pc_q;
                            instr_valid_q <= 1'b1;
                        end else if (skid_valid_q) begin
                            instr_q       <= skid_instr_q;
                            instr_pc_q    <= skid_pc_q;
                            instr_valid_q <= 1'b1;
                            skid_valid_q  <= 1'b0;
                        end else begin
                            instr_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q       <= ST_BOOT;
                    pend_q        <= 1'b0;
                    skid_valid_q  <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: a behavioural reference model tracks
// the fetch address, and a scoreboard queue holds each accepted fetch until
// the DUT presents it on instr/instr_pc.
module tb_fetch_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam int M_BOOT   = 0;
    localparam int M_FETCH  = 1;
    localparam int M_SQUASH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_pc;
    logic [31:0] immediate_32;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;

    always #5 clk = ~clk;

    fetch_pc_unit #(.RESET_VECTOR(RV)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_pc    (branch_pc),
        .immediate_32 (immediate_32),
        .imem_addr    (imem_addr),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    int          m_state;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_valid;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] exp_target(input logic [31:0] bpc, input logic [31:0] imm);
        return bpc + 32'd8 + imm * 32'd4;
    endfunction

    // One clock: check request outputs before the edge, advance the model,
    // drive the memory response, then check the delivered instruction.
    task automatic step();
        logic        acc;
        logic        brk;
        logic        was_reset;
        logic [31:0] acc_addr;
        exp_t        e;
        @(negedge clk);
        chk("imem_addr", imem_addr, m_pc);
        chk("imem_req", 32'(imem_req),
            32'(!reset && (m_state == M_FETCH) && (!stall || branch_taken)));
        acc       = imem_req && imem_ready;
        acc_addr  = imem_addr;
        brk       = branch_taken && (m_state != M_BOOT);
        was_reset = reset;
        @(posedge clk);
        #1;
        imem_rdata = 32'hDEAD_BEEF;
        if (was_reset) begin
            m_state = M_BOOT;
            m_pc    = RV;
            sb.delete();
            m_instr = '0;
            m_ipc   = '0;
            m_valid = 1'b0;
        end else if (brk) begin
            m_pc    = exp_target(branch_pc, immediate_32);
            m_state = M_SQUASH;
            sb.delete();
            m_valid = 1'b0;
        end else if (m_state == M_BOOT) begin
            m_state = M_FETCH;
        end else if (m_state == M_SQUASH) begin
            m_state = M_FETCH;
            m_valid = 1'b0;
        end else if (!stall) begin
            if (sb.size() > 0) begin
                e       = sb.pop_front();
                m_instr = e.data;
                m_ipc   = e.pc;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (acc) begin
                m_pc       = m_pc + 32'd4;
                e.pc       = acc_addr;
                e.data     = mem_word(acc_addr);
                sb.push_back(e);
                imem_rdata = e.data;
            end
        end
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        if (m_valid || was_reset) begin
            chk("instr", instr, m_instr);
            chk("instr_pc", instr_pc, m_ipc);
        end
    endtask

    task automatic run_to(input logic [31:0] target_pc);
        for (int i = 0; i < 40 && imem_addr != target_pc; i++) step();
        chk("reach_pc", imem_addr, target_pc);
    endtask

    initial begin
        reset        = 1'b1;
        stall        = 1'b0;
        branch_taken = 1'b0;
        branch_pc    = '0;
        immediate_32 = '0;
        imem_ready   = 1'b0;
        imem_rdata   = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        m_state = M_BOOT;
        m_pc    = RV;
        m_instr = '0;
        m_ipc   = '0;
        m_valid = 1'b0;

        // Reset values, then streaming fetch with memory always ready.
        step();
        reset      = 1'b0;
        imem_ready = 1'b1;
        step();
        step();
        step();
        chk("first_valid", 32'(instr_valid), 32'd1);
        chk("first_instr_pc", instr_pc, 32'h0);
        chk("third_addr", imem_addr, 32'h8);

        // Downstream stall at 0x20.
        run_to(32'h20);
        stall = 1'b1;
        repeat (3) step();
        chk("stall_addr", imem_addr, 32'h20);
        stall = 1'b0;
        step();
        chk("resume_addr", imem_addr, 32'h24);

        // Memory not ready at 0x40.
        run_to(32'h40);
        imem_ready = 1'b0;
        repeat (2) step();
        chk("notready_addr", imem_addr, 32'h40);
        chk("notready_valid", 32'(instr_valid), 32'd0);
        imem_ready = 1'b1;
        step();
        step();

        // Backward branch: 0x100 + 8 - 12 = 0xFC.
        branch_pc    = 32'h0000_0100;
        immediate_32 = 32'hFFFF_FFFD;
        branch_taken = 1'b1;
        step();
        branch_taken = 1'b0;
        step();
        chk("squash_valid", 32'(instr_valid), 32'd0);
        chk("bwd_target", imem_addr, 32'h0000_00FC);
        chk("bwd_req", 32'(imem_req), 32'd1);
        step();
        step();

        // Branch with stall, target wraps past 2^32.
        branch_pc    = 32'hFFFF_FFF8;
        immediate_32 = 32'h0000_0001;
        branch_taken = 1'b1;
        stall        = 1'b1;
        step();
        branch_taken = 1'b0;
        stall        = 1'b0;
        step();
        chk("wrap_target", imem_addr, 32'h0000_0004);
        step();
        step();

        // Reset while in SQUASH with another redirect pending.
        branch_pc    = 32'h0000_1000;
        immediate_32 = 32'h0000_0010;
        branch_taken = 1'b1;
        step();
        reset = 1'b1;
        step();
        chk("rst_sq_addr", imem_addr, RV);
        chk("rst_sq_valid", 32'(instr_valid), 32'd0);
        reset        = 1'b0;
        branch_taken = 1'b0;
        step();
        step();
        step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            r            = $urandom;
            stall        = ($urandom % 4) == 0;
            imem_ready   = ($urandom % 3) != 0;
            branch_taken = ($urandom % 12) == 0;
            reset        = ($urandom % 97) == 0;
            branch_pc    = $urandom & 32'hFFFF_FFFC;
            immediate_32 = {{22{r[9]}}, r[9:0]};
            step();
        end
        reset        = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        imem_ready   = 1'b1;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-004 stall  in  1  SHALL hold the fetch stage (downstream not ready).
REQ-005 branch_taken  in  1  SHALL request a PC redirect this cycle.
REQ-006 branch_pc  in  32  SHALL be the address of the branch instruction.
REQ-007 immediate_32  in  32  SHALL be the sign-extended 24-bit branch offset from SignExtend_24, in words.
REQ-008 imem_addr  out  32  SHALL be the instruction-memory read address.
REQ-009 imem_req  out  1  SHALL mark imem_addr valid.
REQ-010 imem_ready  in  1  SHALL mark acceptance of the request this cycle.
REQ-011 imem_rdata  in  32  SHALL be the read data, valid one cycle after acceptance.
REQ-012 instr  out  32  SHALL be the fetched instruction.
REQ-013 instr_pc  out  32  SHALL be the address of instr.
REQ-014 instr_valid  out  1  SHALL mark instr/instr_pc valid.

Function
REQ-015 States SHALL be BOOT, FETCH, SQUASH.
REQ-016 BOOT: imem_req=0; next state FETCH unconditionally.
REQ-017 FETCH: imem_req=1, imem_addr=pc, unless stall=1 and branch_taken=0 (then imem_req=0).
REQ-018 Acceptance occurs when imem_req=1 and imem_ready=1; then pc <= pc+4 mod 2^32, and next cycle instr<=imem_rdata, instr_pc<=accepted address, instr_valid<=1.
REQ-019 FETCH with imem_req=1, imem_ready=0: pc and imem_addr held; next cycle instr_valid=0 unless stall holds it.
REQ-020 stall=1, branch_taken=0: pc, instr, instr_pc, instr_valid SHALL hold their values.
REQ-021 branch_taken=1 in any state after BOOT: pc <= branch_pc + 8 + (immediate_32 << 2), 32-bit wrap, ignoring stall; next state SQUASH.
REQ-022 Any request accepted in the redirect cycle SHALL be dropped; instr_valid=0 in the cycle following redirect.
REQ-023 SQUASH: imem_req=0, instr_valid=0; next state FETCH; branch_taken=1 in SQUASH re-redirects and stays SQUASH.
REQ-024 Priority SHALL be reset > branch_taken > stall > normal fetch.
REQ-025 Latency request-accept to instr_valid SHALL be exactly 1 cycle; redirect to first request at target SHALL be 2 cycles.
REQ-026 Offset shift SHALL discard bits [31:30] of immediate_32; no overflow flag.

Reset
REQ-027 reset=1 SHALL set pc=RESET_VECTOR, state=BOOT, imem_req=0, imem_addr=RESET_VECTOR, instr=0, instr_pc=0, instr_valid=0.
REQ-028 reset mid-operation SHALL discard in-flight requests and override branch_taken and stall the same edge.

Structure
REQ-029 Shared package cpu_pkg SHALL hold PC_STEP=4, PC_PIPE_OFFSET=8, and the state encoding.
REQ-030 Target arithmetic SHALL live in one sub-module branch_target_adder (branch_pc, immediate_32 -> target), combinational.

Verification
REQ-031 Reset then imem_ready=1 constant -> imem_addr 0x0,0x4,0x8; instr_valid rises cycle after first accept with instr_pc=0x0.
REQ-032 branch_pc=0x100, immediate_32=0xFFFFFFFD, branch_taken pulse -> next imem_addr 0xFC after one SQUASH cycle, instr_valid=0 in that cycle.
REQ-033 stall=1 for 3 cycles at pc=0x20 -> imem_req=0, instr/instr_pc/instr_valid unchanged, fetch resumes at 0x20.
REQ-034 imem_ready=0 for 2 cycles at pc=0x40 -> imem_addr held at 0x40, pc not advanced, instr_valid=0.
REQ-035 branch_taken with stall=1 simultaneously, branch_pc=0xFFFFFFF8, immediate_32=0x1 -> redirect to 0x4 (wrap), stall ignored.
REQ-036 reset asserted during SQUASH with branch_taken=1 -> state BOOT, pc=RESET_VECTOR, all outputs at reset values next cycle.
